// File: rtl/raster_pkg.sv
// Shared types and helpers for the raster scan counter: FSM state encoding
// and the zero-to-one stride mapping.
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Widest stride input the helper below accepts.
    localparam int MAX_STEP_BITS = 16;

    // A programmed stride of zero would stall the scan, so it is promoted to one.
    function automatic logic [MAX_STEP_BITS-1:0] eff_step(input logic [MAX_STEP_BITS-1:0] step);
        return (step == '0) ? MAX_STEP_BITS'(1) : step;
    endfunction

endpackage

// File: rtl/raster_scan_counter_if.sv
// Coordinate output stream of the raster scan counter: valid/ready handshake
// plus the (col,row) payload and its line/frame boundary flags.
interface raster_scan_counter_if #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10
);
    logic                out_valid;
    logic                out_ready;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                line_start;
    logic                line_end;
    logic                frame_end;

    modport master (
        output out_valid, col, row, line_start, line_end, frame_end,
        input  out_ready
    );

    modport slave (
        input  out_valid, col, row, line_start, line_end, frame_end,
        output out_ready
    );
endinterface

// File: rtl/axis_counter.sv
// One axis of the raster scan: a loadable stride counter with an inclusive
// last value that wraps to zero once the next stride would pass it.
module axis_counter
    import raster_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,      // latch last/step, restart at 0
    input  logic                 clear,     // restart at 0, keep latched config
    input  logic                 en,        // advance by one stride
    input  logic [WIDTH-1:0]     last_in,
    input  logic [STEP_BITS-1:0] step_in,
    output logic [WIDTH-1:0]     value,
    output logic                 at_last
);

    // One extra bit beyond the wider operand so value+step never wraps.
    localparam int SUM_W = ((WIDTH > STEP_BITS) ? WIDTH : STEP_BITS) + 1;

    logic [WIDTH-1:0]     last_q;
    logic [STEP_BITS-1:0] step_q;
    logic [SUM_W-1:0]     sum_ext;

    assign sum_ext = SUM_W'(value) + SUM_W'(step_q);
    assign at_last = (sum_ext > SUM_W'(last_q));

    // NOTE: asynchronous active-low reset; every register here has a defined reset value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_q <= '0;
            step_q <= '0;
        end else if (load) begin
            last_q <= last_in;
            step_q <= STEP_BITS'(eff_step(MAX_STEP_BITS'(step_in)));
        end
    end

    // NOTE: non-blocking assignments for all sequential state so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value <= '0;
        end else if (load || clear) begin
            value <= '0;
        end else if (en) begin
            value <= at_last ? '0 : sum_ext[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/raster_scan_counter.sv
// Raster (col,row) coordinate generator: nested stride counters driven by a
// start/abort run FSM, emitting coordinates over a valid/ready stream.
module raster_scan_counter
    import raster_pkg::*;
#(
    parameter int COL_BITS  = 10,
    parameter int ROW_BITS  = 10,
    parameter int STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COL_BITS-1:0]  col_last,
    input  logic [ROW_BITS-1:0]  row_last,
    input  logic [STEP_BITS-1:0] col_step,
    input  logic [STEP_BITS-1:0] row_step,
    raster_scan_counter_if.master out_if,
    output logic                 busy,
    output logic                 done
);

    scan_state_t state, state_nxt;

    logic                run;
    logic                load;
    logic                transfer;
    logic [COL_BITS-1:0] col_val;
    logic [ROW_BITS-1:0] row_val;
    logic                col_at_last;
    logic                row_at_last;

    assign run      = (state == RUN);
    assign load     = (state == IDLE) && start && !abort;
    assign transfer = run && out_if.out_ready;

    axis_counter #(
        .WIDTH     (COL_BITS),
        .STEP_BITS (STEP_BITS)
    ) u_col (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (load),
        .clear   (abort),
        .en      (transfer),
        .last_in (col_last),
        .step_in (col_step),
        .value   (col_val),
        .at_last (col_at_last)
    );

    // Rows advance only when the column wraps; on the final row both wrap to 0.
    axis_counter #(
        .WIDTH     (ROW_BITS),
        .STEP_BITS (STEP_BITS)
    ) u_row (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (load),
        .clear   (abort),
        .en      (transfer && col_at_last),
        .last_in (row_last),
        .step_in (row_step),
        .value   (row_val),
        .at_last (row_at_last)
    );

    // NOTE: next-state defaults to the current state before the case, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (transfer && col_at_last && row_at_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Flags come only from registered coordinates and latched config.
    assign out_if.out_valid  = run;
    assign out_if.col        = col_val;
    assign out_if.row        = row_val;
    assign out_if.line_start = run && (col_val == '0);
    assign out_if.line_end   = run && col_at_last;
    assign out_if.frame_end  = run && col_at_last && row_at_last;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_raster_scan_counter.sv
// Directed self-checking bench for raster_scan_counter (4-bit axes so the
// column overflow edge is reachable).
module tb_raster_scan_counter;

    localparam int CB = 4;
    localparam int RB = 4;
    localparam int SB = 4;

    typedef struct {
        int c;
        int r;
        bit ls;
        bit le;
        bit fe;
    } coord_t;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic          abort;
    logic [CB-1:0] col_last;
    logic [RB-1:0] row_last;
    logic [SB-1:0] col_step;
    logic [SB-1:0] row_step;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    coord_t exp_q[$];

    raster_scan_counter_if #(.COL_BITS(CB), .ROW_BITS(RB)) out_if ();

    raster_scan_counter #(
        .COL_BITS  (CB),
        .ROW_BITS  (RB),
        .STEP_BITS (SB)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .abort    (abort),
        .col_last (col_last),
        .row_last (row_last),
        .col_step (col_step),
        .row_step (row_step),
        .out_if   (out_if.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int c, input int r, input bit ls, input bit le, input bit fe);
        coord_t e;
        e.c = c; e.r = r; e.ls = ls; e.le = le; e.fe = fe;
        exp_q.push_back(e);
    endfunction

    // Reference raster order built with plain integer loops.
    function automatic void build_model(input int cl, input int rl, input int cs, input int rs);
        int ecs = (cs == 0) ? 1 : cs;
        int ers = (rs == 0) ? 1 : rs;
        exp_q.delete();
        for (int r = 0; r <= rl; r += ers)
            for (int c = 0; c <= cl; c += ecs)
                add(c, r, c == 0, c + ecs > cl, (c + ecs > cl) && (r + ers > rl));
    endfunction

    task automatic start_frame(input int cl, input int rl, input int cs, input int rs);
        col_last = CB'(cl);
        row_last = RB'(rl);
        col_step = SB'(cs);
        row_step = SB'(rs);
        out_ready_drive(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic out_ready_drive(input logic v);
        out_if.out_ready = v;
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0; 2: always ready plus
    // a stray start and a config change while the frame is running.
    task automatic run_frame(input string tag, input int mode);
        int idx = 0;
        int cyc = 0;
        while (idx < exp_q.size() && cyc < 300) begin
            out_ready_drive((mode == 1) ? (cyc % 3 == 0) : 1'b1);
            if (mode == 2) begin
                start = (cyc == 2);
                if (cyc == 1) begin
                    col_last = 4'd1; row_last = 4'd0; col_step = 4'd7; row_step = 4'd7;
                end
            end
            check({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
            check({tag, "_coord"}, {16'(out_if.col), 16'(out_if.row)},
                  {16'(exp_q[idx].c), 16'(exp_q[idx].r)});
            check({tag, "_flags"}, {29'd0, out_if.line_start, out_if.line_end, out_if.frame_end},
                  {29'd0, exp_q[idx].ls, exp_q[idx].le, exp_q[idx].fe});
            check({tag, "_nodone"}, 32'(done), 32'd0);
            if (out_if.out_ready) idx++;
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready_drive(1'b1);
        check({tag, "_count"}, 32'(idx), 32'(exp_q.size()));
        check({tag, "_done"}, {30'd0, done, out_if.out_valid}, {30'd0, 1'b1, 1'b0});
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        col_last = '0; row_last = '0; col_step = '0; row_step = '0;
        out_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {16'(out_if.col), 8'(out_if.row), 3'd0, out_if.out_valid, out_if.line_start,
               out_if.line_end, out_if.frame_end, busy | done}, 32'd0);
        n_rst = 1'b1;
        tick();
        check("reset_idle", {30'd0, busy, done}, 32'd0);

        // Basic 3x2 frame, hand table.
        exp_q.delete();
        add(0, 0, 1, 0, 0); add(1, 0, 0, 0, 0); add(2, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0); add(1, 1, 0, 0, 0); add(2, 1, 0, 1, 1);
        start_frame(2, 1, 1, 1);
        run_frame("basic", 0);

        // Same frame under backpressure.
        start_frame(2, 1, 1, 1);
        run_frame("bp", 1);

        // Strides, with stray start and config change mid-frame.
        build_model(9, 4, 4, 2);
        start_frame(9, 4, 4, 2);
        run_frame("stride", 2);

        // Column overflow edge: 15 + 3 must end the line, not wrap.
        exp_q.delete();
        add(0, 0, 1, 0, 0); add(3, 0, 0, 0, 0); add(6, 0, 0, 0, 0);
        add(9, 0, 0, 0, 0); add(12, 0, 0, 0, 0); add(15, 0, 0, 1, 1);
        start_frame(15, 0, 3, 1);
        run_frame("ovf15", 0);

        build_model(14, 0, 3, 1);
        start_frame(14, 0, 3, 1);
        run_frame("ovf14", 0);

        // Zero strides behave as one.
        build_model(2, 1, 0, 0);
        start_frame(2, 1, 0, 0);
        run_frame("step0", 0);

        // Single-column and single-coordinate frames.
        build_model(0, 2, 1, 1);
        start_frame(0, 2, 1, 1);
        run_frame("col0", 0);

        exp_q.delete();
        add(0, 0, 1, 1, 1);
        start_frame(0, 0, 1, 1);
        run_frame("single", 0);

        // Abort at (1,0).
        start_frame(2, 1, 1, 1);
        check("abort_first", {16'(out_if.col), 16'(out_if.row)}, 32'h0000_0000);
        tick();
        check("abort_at", {16'(out_if.col), 16'(out_if.row)}, 32'h0001_0000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", {28'd0, out_if.out_valid, busy, done, |{out_if.col, out_if.row}}, 32'd0);
        tick();
        check("abort_nodone", {30'd0, done, busy}, 32'd0);

        // abort and start together in IDLE.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start", {30'd0, busy, out_if.out_valid}, 32'd0);
        tick();
        check("abort_start_idle", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset at (1,1) of a 4x4 frame.
        build_model(3, 3, 1, 1);
        start_frame(3, 3, 1, 1);
        for (int i = 0; i < 5; i++) tick();
        check("rst_at", {16'(out_if.col), 16'(out_if.row)}, 32'h0001_0001);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_async",
              {16'(out_if.col), 8'(out_if.row), 3'd0, out_if.out_valid, out_if.line_start,
               out_if.line_end, out_if.frame_end, busy | done}, 32'd0);
        #2;
        n_rst = 1'b1;
        tick();
        check("rst_release", {30'd0, busy, done}, 32'd0);
        start_frame(3, 3, 1, 1);
        run_frame("rst_restart", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/raster_scan_counter.md
Name: raster_scan_counter

Overview:
- Two-axis generalisation of the flex counter: a column counter nested inside a row counter.
- Produces a raster sequence of (col, row) pixel coordinates with runtime-programmable extents and strides, for window/patch addressing in the FAST corner pipeline.
- Output uses a valid/ready handshake.
- Adds start/abort control, a run FSM, and line/frame boundary flags that a single flex counter lacks.

Parameters:
COL_BITS, 10, width of column coordinate and col_last
ROW_BITS, 10, width of row coordinate and row_last
STEP_BITS, 4, width of col_step/row_step stride inputs

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
start  in  1  pulse; begins a frame when FSM is IDLE, ignored otherwise
abort  in  1  synchronous; returns FSM to IDLE from any state
col_last  in  COL_BITS  largest legal column value (inclusive)
row_last  in  ROW_BITS  largest legal row value (inclusive)
col_step  in  STEP_BITS  column stride (0 treated as 1)
row_step  in  STEP_BITS  row stride (0 treated as 1)
out_ready  in  1  downstream accepts coordinate
out_valid  out  1  coordinate valid
col  out  COL_BITS  current column
row  out  ROW_BITS  current row
line_start  out  1  out_valid && col==0
line_end  out  1  out_valid && current col is last in its row
frame_end  out  1  line_end && current row is last row
busy  out  1  FSM != IDLE
done  out  1  one-cycle pulse after the last coordinate is accepted

Behaviour:
- Reset: FSM=IDLE; col=0, row=0; latched config=0; all flag outputs 0; done=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start. In that same edge:
  - latch col_last, row_last and effective steps (max(step,1));
  - clear col and row to 0.
  - out_valid=1 from the next cycle (latency 1).
- RUN: out_valid=1. A transfer occurs when out_valid && out_ready.
- No transfer: col, row and all flags hold stable.
- On transfer, evaluate in order:
  - if col+cstep > col_last: col<=0, then
    - if row+rstep > row_last: FSM<=DONE (row/col then cleared to 0);
    - else row<=row+rstep;
  - else col<=col+cstep.
- Arithmetic widths: comparisons use COL_BITS+1 / ROW_BITS+1 bit sums so no wrap-around. Example: col_last=2^COL_BITS-1 with col at max correctly ends the line.
- line_end, frame_end and line_start are combinational from registered col/row and latched config only. They are glitch-free and do not depend on out_ready.
- DONE: out_valid=0, done=1 for exactly one cycle, then IDLE unconditionally.
- Config inputs changing during RUN have no effect until the next start.
- start during RUN or DONE: ignored, no restart.
- abort (any state): next state IDLE, col/row cleared, no done pulse. abort has priority over start in the same cycle.
- col_last=0: one coordinate per row; line_start and line_end are both asserted on it.
- col_last=0 and row_last=0: single-coordinate frame with all three flags asserted.
- n_rst mid-frame: immediate return to reset values; no done.
- busy=1 in RUN and DONE.

Decomposition:
- Package raster_pkg:
  - typedef enum logic [1:0] scan_state_t {IDLE, RUN, DONE};
  - helper function for effective step (zero→1).
- Sub-module axis_counter #(WIDTH, STEP_BITS):
  - one loadable stride counter with inclusive last value, clear, enable, and a combinational "at_last" output (next step exceeds last);
  - instantiated once for columns and once for rows;
  - row instance enabled by transfer && col at_last.
- FSM and handshake live in the top module.

Test Plan:
- Basic frame: col_last=2, row_last=1, steps=1, out_ready=1, start at cycle 0.
  - Cycles 1-6 emit (0,0)(1,0)(2,0)(0,1)(1,1)(2,1).
  - line_start on (0,*); line_end on (2,*); frame_end on (2,1).
  - done=1 at cycle 7; busy=0 at cycle 8.
- Stride: col_last=9, col_step=4, row_last=4, row_step=2.
  - Cols 0,4,8 with line_end at 8; rows 0,2,4; 9 coordinates; done after (8,4).
- Overflow edge: COL_BITS=4.
  - col_last=15, step 3 -> cols 0,3,6,9,12,15, line_end at 15.
  - col_last=14, step 3 -> last col 12.
  - col_step=0 behaves as step 1.
- Backpressure: basic frame with out_ready toggled 1,0,0,1,...
  - Coordinates and flags hold while out_ready=0.
  - Sequence unchanged, no duplicates or skips; done only after final accept.
- Control hazards:
  - start while busy is ignored.
  - abort at coordinate (1,0) -> out_valid=0 next cycle, busy=0, no done.
  - abort+start in the same IDLE cycle -> stays IDLE.
  - config change mid-frame has no effect.
- Reset: assert n_rst low at (1,1) of a 4x4 frame.
  - Outputs go to 0 asynchronously.
  - After release, a new start restarts from (0,0).
